// File: rtl/prefix_subtractor32_pipe_if.sv
// Operand/result handshake bundle for the pipelined prefix subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface prefix_subtractor32_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/prefix_subtractor32_pipe.sv
// Two-stage 32-bit subtractor computing a + ~b + ~bin on a Kogge-Stone carry tree,
// with borrow/overflow/zero flags and a fully back-pressured valid/ready pipeline.
module prefix_subtractor32_pipe (
    input  logic                             clk,
    input  logic                             rst_n,
    prefix_subtractor32_pipe_if.slave        bus
);

    // One radix-2 prefix level: combine each (G,P) with the pair 'span' bits below.
    function automatic logic [63:0] prefix_level(input logic [31:0] g_in,
                                                 input logic [31:0] p_in,
                                                 input int          span);
        logic [31:0] g_out;
        logic [31:0] p_out;
        for (int i = 0; i < 32; i++) begin
            if (i >= span) begin
                g_out[i] = g_in[i] | (p_in[i] & g_in[i - span]);
                p_out[i] = p_in[i] & p_in[i - span];
            end else begin
                g_out[i] = g_in[i];
                p_out[i] = p_in[i];
            end
        end
        return {g_out, p_out};
    endfunction

    logic        s1_valid_r;
    logic [31:0] s1_g_r;
    logic [31:0] s1_pp_r;
    logic [31:0] s1_p_r;
    logic        s1_c0_r;
    logic        s1_a31_r;
    logic        s1_b31_r;

    logic        out_valid_r;
    logic [31:0] diff_r;
    logic        bout_r;
    logic        ovf_r;
    logic        zero_r;

    logic        s2_adv_s;
    logic        in_ready_s;
    logic        s1_load_s;

    logic        c0_s;
    logic [31:0] g_s, p_s, g0_s;
    logic [31:0] g1_s, p1_s, g2_s, p2_s;
    logic [31:0] g3_s, p3_s, g4_s, p4_s, g5_s, p5_s;
    logic [31:0] carry_s;
    logic [31:0] diff_s;
    logic        bout_s;
    logic        ovf_s;
    logic        zero_s;

    // Handshake: stage 2 frees when empty or drained; stage 1 frees when empty or advancing.
    always_comb begin
        s2_adv_s   = ~out_valid_r | bus.out_ready;
        in_ready_s = (~s1_valid_r | s2_adv_s) & rst_n;
        s1_load_s  = bus.in_valid & in_ready_s;
    end

    // Stage 1 logic: bit terms with the carry-in folded into bit 0, then spans 1 and 2.
    always_comb begin
        c0_s    = ~bus.bin;
        g_s     = bus.a & ~bus.b;
        p_s     = bus.a ^ ~bus.b;
        g0_s    = g_s;
        g0_s[0] = g_s[0] | (p_s[0] & c0_s);
        {g1_s, p1_s} = prefix_level(g0_s, p_s, 1);
        {g2_s, p2_s} = prefix_level(g1_s, p1_s, 2);
    end

    // Stage 1 registers: partial tree plus what stage 2 needs for sum and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_g_r     <= 32'd0;
            s1_pp_r    <= 32'd0;
            s1_p_r     <= 32'd0;
            s1_c0_r    <= 1'b0;
            s1_a31_r   <= 1'b0;
            s1_b31_r   <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= bus.in_valid;
            end
            if (s1_load_s) begin
                s1_g_r   <= g2_s;
                s1_pp_r  <= p2_s;
                s1_p_r   <= p_s;
                s1_c0_r  <= c0_s;
                s1_a31_r <= bus.a[31];
                s1_b31_r <= bus.b[31];
            end
        end
    end

    // Stage 2 logic: spans 4, 8, 16; G[i] is the carry out of bit i including c0.
    always_comb begin
        {g3_s, p3_s} = prefix_level(s1_g_r, s1_pp_r, 4);
        {g4_s, p4_s} = prefix_level(g3_s, p3_s, 8);
        {g5_s, p5_s} = prefix_level(g4_s, p4_s, 16);
        carry_s = {g5_s[30:0], s1_c0_r};
        diff_s  = s1_p_r ^ carry_s;
        bout_s  = ~g5_s[31];
        ovf_s   = (s1_a31_r != s1_b31_r) & (diff_s[31] != s1_a31_r);
        zero_s  = (diff_s == 32'd0);
    end

    // Stage 2 registers: result and flags, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            diff_r      <= 32'd0;
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                diff_r <= diff_s;
                bout_r <= bout_s;
                ovf_r  <= ovf_s;
                zero_r <= zero_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_prefix_subtractor32_pipe.sv
// Directed-vector bench for prefix_subtractor32_pipe: reset, arithmetic corners,
// backpressure streaming and mid-stream reset.
module tb_prefix_subtractor32_pipe;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    prefix_subtractor32_pipe_if bus_if ();

    prefix_subtractor32_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: {ovf, bout, diff}.
    function automatic logic [33:0] ref_sub(input logic [31:0] a_v, input logic [31:0] b_v,
                                            input logic bin_v);
        logic [32:0] w;
        logic        o;
        w = {1'b0, a_v} - {1'b0, b_v} - {32'd0, bin_v};
        o = (a_v[31] != b_v[31]) && (w[31] != a_v[31]);
        return {o, w[32], w[31:0]};
    endfunction

    // Drive one transaction from the posedge+1 phase and wait (bounded) for its result.
    task automatic send_one(input logic [31:0] a_v, input logic [31:0] b_v, input logic bin_v,
                            output logic [31:0] d, output logic bo, output logic ov,
                            output logic z, output int lat, output logic rdy);
        bus_if.a = a_v;
        bus_if.b = b_v;
        bus_if.bin = bin_v;
        bus_if.in_valid = 1'b1;
        bus_if.out_ready = 1'b1;
        #1;
        rdy = bus_if.in_ready;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (!bus_if.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = bus_if.diff;
        bo = bus_if.bout;
        ov = bus_if.ovf;
        z  = bus_if.zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.a = 32'd5;
        bus_if.b = 32'd3;
        bus_if.bin = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus_if.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0", bus_if.in_ready);
        end
        tests_run++;
        if (bus_if.out_valid !== 1'b0 || bus_if.diff !== 32'd0 || bus_if.bout !== 1'b0 ||
            bus_if.ovf !== 1'b0 || bus_if.zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b d=%h b=%b o=%b z=%b want all 0",
                     bus_if.out_valid, bus_if.diff, bus_if.bout, bus_if.ovf, bus_if.zero);
        end
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0",
                     bus_if.in_ready, bus_if.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic        tbin [5];
        logic [31:0] ed [5];
        logic        eb [5];
        logic        eo [5];
        logic        ez [5];
        logic [31:0] d;
        logic        bo, ov, z, rdy;
        int          lat;
        ta[0] = 32'h0000_0005; tb[0] = 32'h0000_0003; tbin[0] = 1'b0;
        ed[0] = 32'h0000_0002; eb[0] = 1'b0; eo[0] = 1'b0; ez[0] = 1'b0;
        ta[1] = 32'h0000_0000; tb[1] = 32'h0000_0001; tbin[1] = 1'b0;
        ed[1] = 32'hFFFF_FFFF; eb[1] = 1'b1; eo[1] = 1'b0; ez[1] = 1'b0;
        ta[2] = 32'h8000_0000; tb[2] = 32'h0000_0001; tbin[2] = 1'b0;
        ed[2] = 32'h7FFF_FFFF; eb[2] = 1'b0; eo[2] = 1'b1; ez[2] = 1'b0;
        ta[3] = 32'h1234_5678; tb[3] = 32'h1234_5677; tbin[3] = 1'b1;
        ed[3] = 32'h0000_0000; eb[3] = 1'b0; eo[3] = 1'b0; ez[3] = 1'b1;
        ta[4] = 32'hFFFF_FFFF; tb[4] = 32'hFFFF_FFFF; tbin[4] = 1'b1;
        ed[4] = 32'hFFFF_FFFF; eb[4] = 1'b1; eo[4] = 1'b0; ez[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_one(ta[i], tb[i], tbin[i], d, bo, ov, z, lat, rdy);
            tests_run++;
            if (rdy !== 1'b1 || lat !== 1) begin
                tests_failed++;
                $display("FAIL vec%0d_timing: got rdy=%b lat=%0d want rdy=1 lat=1", i, rdy, lat);
            end
            tests_run++;
            if (d !== ed[i] || bo !== eb[i] || ov !== eo[i] || z !== ez[i]) begin
                tests_failed++;
                $display("FAIL vec%0d_result: got d=%h b=%b o=%b z=%b want d=%h b=%b o=%b z=%b",
                         i, d, bo, ov, z, ed[i], eb[i], eo[i], ez[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic        vbin [6];
        logic [33:0] exp_v;
        logic [31:0] prev_diff;
        logic        prev_hold, saw_full, acc, drn;
        int          sent, got, stall, cyc;
        va[0] = 32'h0000_000A; vb[0] = 32'h0000_0003; vbin[0] = 1'b0;
        va[1] = 32'h0000_0001; vb[1] = 32'h0000_0002; vbin[1] = 1'b0;
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'hFFFF_FFFF; vbin[2] = 1'b0;
        va[3] = 32'hDEAD_BEEF; vb[3] = 32'h1234_5678; vbin[3] = 1'b1;
        va[4] = 32'h0000_0000; vb[4] = 32'h0000_0000; vbin[4] = 1'b1;
        va[5] = 32'h8000_0000; vb[5] = 32'h8000_0000; vbin[5] = 1'b0;
        sent = 0; got = 0; stall = 0; cyc = 0;
        prev_hold = 1'b0; saw_full = 1'b0; prev_diff = 32'd0;
        while (got < 6 && cyc < 60) begin
            bus_if.in_valid = (sent < 6);
            if (sent < 6) begin
                bus_if.a = va[sent];
                bus_if.b = vb[sent];
                bus_if.bin = vbin[sent];
            end
            bus_if.out_ready = (stall == 0);
            #1;
            if (prev_hold) begin
                tests_run++;
                if (bus_if.diff !== prev_diff || bus_if.out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h",
                             bus_if.out_valid, bus_if.diff, prev_diff);
                end
            end
            if (bus_if.in_valid && !bus_if.in_ready) saw_full = 1'b1;
            acc = bus_if.in_valid & bus_if.in_ready;
            drn = bus_if.out_valid & bus_if.out_ready;
            if (!bus_if.out_ready) stall--;
            if (drn) begin
                exp_v = ref_sub(va[got], vb[got], vbin[got]);
                tests_run++;
                if (bus_if.diff !== exp_v[31:0] || bus_if.bout !== exp_v[32] ||
                    bus_if.ovf !== exp_v[33] || bus_if.zero !== (exp_v[31:0] == 32'd0)) begin
                    tests_failed++;
                    $display("FAIL stream%0d: got d=%h b=%b o=%b z=%b want d=%h b=%b o=%b",
                             got, bus_if.diff, bus_if.bout, bus_if.ovf, bus_if.zero,
                             exp_v[31:0], exp_v[32], exp_v[33]);
                end
                got++;
                if (got == 1) stall = 3;
            end
            prev_hold = bus_if.out_valid & ~bus_if.out_ready;
            prev_diff = bus_if.diff;
            if (acc) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        tests_run++;
        if (got !== 6) begin
            tests_failed++;
            $display("FAIL stream_count: got %0d results want 6", got);
        end
        tests_run++;
        if (saw_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_in_ready_drop: got saw_full=%b want 1", saw_full);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] d;
        logic        bo, ov, z, rdy, stale;
        int          lat;
        bus_if.out_ready = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.a = 32'd100; bus_if.b = 32'd1; bus_if.bin = 1'b0;
        @(posedge clk); #1;
        bus_if.a = 32'd200; bus_if.b = 32'd2;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        tests_run++;
        if (bus_if.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_inflight: got v=%b want 1", bus_if.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0 || bus_if.diff !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrst_clear: got v=%b rdy=%b d=%h want 0 0 0",
                     bus_if.out_valid, bus_if.in_ready, bus_if.diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) stale = 1'b1;
        end
        tests_run++;
        if (stale !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_stale: got stale=%b want 0", stale);
        end
        send_one(32'h0000_0010, 32'h0000_0003, 1'b0, d, bo, ov, z, lat, rdy);
        tests_run++;
        if (d !== 32'h0000_000D || bo !== 1'b0 || ov !== 1'b0 || z !== 1'b0 || lat !== 1) begin
            tests_failed++;
            $display("FAIL midrst_next: got d=%h b=%b o=%b z=%b lat=%0d want d=0000000d 0 0 0 lat=1",
                     d, bo, ov, z, lat);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
